// File: rtl/sdram_port_arb.sv
// sdram_port_arb: shares one SDRAM controller command port between N requesters.
// Port 0 is the ioctl ROM loader and is the only port served while a download runs;
// otherwise grants rotate round-robin. A sticky timeout flag reports a stalled access.
module sdram_port_arb #(
   parameter int unsigned N       = 3,
   parameter int unsigned AW      = 25,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic            dl_active,
   input  logic [N-1:0]    m_req,
   input  logic [N-1:0]    m_we,
   input  logic [N*AW-1:0] m_addr,
   input  logic [N*16-1:0] m_wdata,
   input  logic [N*2-1:0]  m_be,
   output logic [N-1:0]    m_ack,
   output logic [15:0]     m_rdata,
   output logic            s_req,
   output logic            s_we,
   output logic [AW-1:0]   s_addr,
   output logic [15:0]     s_wdata,
   output logic [1:0]      s_be,
   input  logic            s_ack,
   input  logic [15:0]     s_rdata,
   output logic            err
);

   localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   rr_q, rr_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            s_req_q, s_req_d;
   logic            s_we_q, s_we_d;
   logic [AW-1:0]   s_addr_q, s_addr_d;
   logic [15:0]     s_wdata_q, s_wdata_d;
   logic [1:0]      s_be_q, s_be_d;
   logic [N-1:0]    m_ack_q, m_ack_d;
   logic [15:0]     m_rdata_q, m_rdata_d;

   logic [N-1:0]    eligible;
   logic            pick_valid;
   logic [GW-1:0]   pick;

   // Round-robin pick: first eligible port scanning from rr+1, wrapping back to rr last.
   always_comb begin
      int unsigned idx;
      eligible   = m_req;
      if (dl_active) begin
         eligible = m_req & N'(1);
      end
      pick_valid = 1'b0;
      pick       = rr_q;
      idx        = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = (32'(rr_q) + i) % N;
         if (!pick_valid && eligible[idx]) begin
            pick_valid = 1'b1;
            pick       = GW'(idx);
         end
      end
   end

   // Next-state logic for the grant FSM, command latches, completion and timeout.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      s_req_d   = s_req_q;
      s_we_d    = s_we_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_be_d    = s_be_q;
      m_ack_d   = '0;
      m_rdata_d = m_rdata_q;

      unique case (state_q)
         StIdle: begin
            // Counter restarts on every BUSY entry; s_ack here is ignored.
            cnt_d = '0;
            if (pick_valid) begin
               grant_d   = pick;
               rr_d      = pick;
               s_we_d    = m_we[pick];
               s_addr_d  = m_addr[32'(pick)*AW +: AW];
               s_wdata_d = m_wdata[32'(pick)*16 +: 16];
               s_be_d    = m_be[32'(pick)*2 +: 2];
               s_req_d   = 1'b1;
               state_d   = StBusy;
            end
         end
         StBusy: begin
            if (s_ack) begin
               s_req_d          = 1'b0;
               m_ack_d[grant_q] = 1'b1;
               m_rdata_d        = s_rdata;
               state_d          = StIdle;
            end else begin
               // Saturate so a long stall cannot wrap and re-fire.
               if (cnt_q != CW'(TIMEOUT)) begin
                  cnt_d = cnt_q + CW'(1);
               end
               if (cnt_d == CW'(TIMEOUT)) begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            s_req_d = 1'b0;
         end
      endcase
   end

   // State registers; reset drops all outputs immediately, abandoning any access.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         rr_q      <= '0;
         grant_q   <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         s_req_q   <= 1'b0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_be_q    <= '0;
         m_ack_q   <= '0;
         m_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         s_req_q   <= s_req_d;
         s_we_q    <= s_we_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_be_q    <= s_be_d;
         m_ack_q   <= m_ack_d;
         m_rdata_q <= m_rdata_d;
      end
   end

   assign s_req   = s_req_q;
   assign s_we    = s_we_q;
   assign s_addr  = s_addr_q;
   assign s_wdata = s_wdata_q;
   assign s_be    = s_be_q;
   assign m_ack   = m_ack_q;
   assign m_rdata = m_rdata_q;
   assign err     = err_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: latency, round-robin, download filter, timeout, reset.
module tb_sdram_port_arb;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 25;

   logic            clk_sys;
   logic            reset;
   logic            dl_active;
   logic [N-1:0]    m_req;
   logic [N-1:0]    m_we;
   logic [N*AW-1:0] m_addr;
   logic [N*16-1:0] m_wdata;
   logic [N*2-1:0]  m_be;
   logic [N-1:0]    m_ack;
   logic [15:0]     m_rdata;
   logic            s_req;
   logic            s_we;
   logic [AW-1:0]   s_addr;
   logic [15:0]     s_wdata;
   logic [1:0]      s_be;
   logic            s_ack;
   logic [15:0]     s_rdata;
   logic            err;

   int vec_cnt = 0;
   int err_cnt = 0;

   sdram_port_arb #(.N(N), .AW(AW), .TIMEOUT(15)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .dl_active (dl_active),
      .m_req     (m_req),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_be      (m_be),
      .m_ack     (m_ack),
      .m_rdata   (m_rdata),
      .s_req     (s_req),
      .s_we      (s_we),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_be      (s_be),
      .s_ack     (s_ack),
      .s_rdata   (s_rdata),
      .err       (err)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic clear_inputs();
      dl_active = 1'b0;
      m_req     = '0;
      m_we      = '0;
      m_addr    = '0;
      m_wdata   = '0;
      m_be      = '0;
      s_ack     = 1'b0;
      s_rdata   = '0;
      m_addr[1*AW +: AW] = 25'h0000100;
      m_addr[2*AW +: AW] = 25'h0000200;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Bounded wait for s_req; leaves the bench in the first cycle s_req is high.
   task automatic wait_sreq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (s_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // One-cycle controller completion; returns in the cycle m_ack should be visible.
   task automatic pulse_ack(input logic [15:0] d);
      s_ack   = 1'b1;
      s_rdata = d;
      tick();
      s_ack   = 1'b0;
      s_rdata = 16'h0000;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      vec_cnt++;
      if ({s_req, s_we, s_addr, s_wdata, s_be, m_ack, m_rdata, err} !== '0) begin
         $display("FAIL reset_outputs: got req=%b ack=%b err=%b addr=%h expected all zero",
                  s_req, m_ack, err, s_addr);
         err_cnt++;
      end
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      do_reset();
      m_req[1]           = 1'b1;
      m_addr[1*AW +: AW] = 25'h0001000;
      vec_cnt++;
      if (s_req !== 1'b0) begin
         $display("FAIL read_sreq_early: got %b expected 0", s_req);
         err_cnt++;
      end
      tick();
      vec_cnt++;
      if (s_req !== 1'b1 || s_addr !== 25'h0001000 || s_we !== 1'b0) begin
         $display("FAIL read_cmd: got req=%b addr=%h we=%b expected 1 0001000 0",
                  s_req, s_addr, s_we);
         err_cnt++;
      end
      for (int i = 0; i < 4; i++) tick();
      vec_cnt++;
      if (m_ack !== 3'b000 || s_req !== 1'b1) begin
         $display("FAIL read_wait: got ack=%b req=%b expected 000 1", m_ack, s_req);
         err_cnt++;
      end
      pulse_ack(16'hBEEF);
      m_req = '0;
      vec_cnt++;
      if (m_ack !== 3'b010 || m_rdata !== 16'hBEEF || s_req !== 1'b0) begin
         $display("FAIL read_ack: got ack=%b rdata=%h req=%b expected 010 beef 0",
                  m_ack, m_rdata, s_req);
         err_cnt++;
      end
      tick();
      vec_cnt++;
      if (m_ack !== 3'b000 || s_req !== 1'b0) begin
         $display("FAIL read_ack_pulse: got ack=%b req=%b expected 000 0", m_ack, s_req);
         err_cnt++;
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [2:0]    exp_ack;
      logic [AW-1:0] exp_addr;
      do_reset();
      m_req = 3'b110;
      for (int k = 0; k < 8; k++) begin
         exp_ack  = (k % 2 == 0) ? 3'b010 : 3'b100;
         exp_addr = (k % 2 == 0) ? 25'h0000100 : 25'h0000200;
         wait_sreq(ok);
         vec_cnt++;
         if (!ok || s_addr !== exp_addr) begin
            $display("FAIL rr_grant%0d: got ok=%b addr=%h expected 1 %h", k, ok, s_addr, exp_addr);
            err_cnt++;
         end
         tick();
         pulse_ack(16'(k));
         vec_cnt++;
         if (m_ack !== exp_ack || m_rdata !== 16'(k)) begin
            $display("FAIL rr_ack%0d: got ack=%b rdata=%h expected %b %h",
                     k, m_ack, m_rdata, exp_ack, 16'(k));
            err_cnt++;
         end
      end
      m_req = '0;
      tick();
   endtask

   task automatic test_download();
      bit ok;
      do_reset();
      dl_active      = 1'b1;
      m_req          = 3'b011;
      m_we[0]        = 1'b1;
      m_wdata[15:0]  = 16'h1234;
      m_be[1:0]      = 2'b11;
      for (int k = 0; k < 4; k++) begin
         m_addr[AW-1:0] = AW'(2 * k);
         wait_sreq(ok);
         vec_cnt++;
         if (!ok || s_addr !== AW'(2 * k) || s_we !== 1'b1 || s_wdata !== 16'h1234
             || s_be !== 2'b11) begin
            $display("FAIL dl_write%0d: got ok=%b addr=%h we=%b wdata=%h be=%b expected 1 %h 1 1234 11",
                     k, ok, s_addr, s_we, s_wdata, s_be, AW'(2 * k));
            err_cnt++;
         end
         tick();
         pulse_ack(16'h0000);
         vec_cnt++;
         if (m_ack !== 3'b001) begin
            $display("FAIL dl_ack%0d: got %b expected 001", k, m_ack);
            err_cnt++;
         end
      end
      m_req[0]  = 1'b0;
      dl_active = 1'b0;
      wait_sreq(ok);
      vec_cnt++;
      if (!ok || s_addr !== 25'h0000100 || s_we !== 1'b0) begin
         $display("FAIL dl_after: got ok=%b addr=%h we=%b expected 1 0000100 0", ok, s_addr, s_we);
         err_cnt++;
      end
      tick();
      pulse_ack(16'h0101);
      m_req = '0;
      vec_cnt++;
      if (m_ack !== 3'b010) begin
         $display("FAIL dl_after_ack: got %b expected 010", m_ack);
         err_cnt++;
      end
      tick();
   endtask

   task automatic test_dl_mid_access();
      bit ok;
      do_reset();
      m_req = 3'b100;
      wait_sreq(ok);
      vec_cnt++;
      if (!ok || s_addr !== 25'h0000200) begin
         $display("FAIL mid_grant2: got ok=%b addr=%h expected 1 0000200", ok, s_addr);
         err_cnt++;
      end
      dl_active = 1'b1;
      m_req     = 3'b111;
      tick();
      pulse_ack(16'h2222);
      vec_cnt++;
      if (m_ack !== 3'b100 || m_rdata !== 16'h2222) begin
         $display("FAIL mid_ack2: got ack=%b rdata=%h expected 100 2222", m_ack, m_rdata);
         err_cnt++;
      end
      for (int k = 0; k < 2; k++) begin
         wait_sreq(ok);
         vec_cnt++;
         if (!ok || s_addr !== 25'h0000000) begin
            $display("FAIL mid_port0_%0d: got ok=%b addr=%h expected 1 0000000", k, ok, s_addr);
            err_cnt++;
         end
         tick();
         pulse_ack(16'h0000);
         vec_cnt++;
         if (m_ack !== 3'b001) begin
            $display("FAIL mid_port0_ack%0d: got %b expected 001", k, m_ack);
            err_cnt++;
         end
      end
      m_req     = '0;
      dl_active = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      bit ok;
      do_reset();
      m_req = 3'b010;
      wait_sreq(ok);
      vec_cnt++;
      if (!ok || err !== 1'b0) begin
         $display("FAIL to_start: got ok=%b err=%b expected 1 0", ok, err);
         err_cnt++;
      end
      for (int i = 0; i < 14; i++) tick();
      vec_cnt++;
      if (err !== 1'b0) begin
         $display("FAIL to_err_14: got %b expected 0", err);
         err_cnt++;
      end
      tick();
      vec_cnt++;
      if (err !== 1'b1) begin
         $display("FAIL to_err_15: got %b expected 1", err);
         err_cnt++;
      end
      tick();
      tick();
      pulse_ack(16'h5A5A);
      m_req = '0;
      vec_cnt++;
      if (m_ack !== 3'b010 || m_rdata !== 16'h5A5A || err !== 1'b1) begin
         $display("FAIL to_late_ack: got ack=%b rdata=%h err=%b expected 010 5a5a 1",
                  m_ack, m_rdata, err);
         err_cnt++;
      end
      tick();
      tick();
      vec_cnt++;
      if (err !== 1'b1) begin
         $display("FAIL to_sticky: got %b expected 1", err);
         err_cnt++;
      end
   endtask

   task automatic test_reset_mid_access();
      bit ok;
      do_reset();
      m_req = 3'b010;
      wait_sreq(ok);
      for (int i = 0; i < 16; i++) tick();
      vec_cnt++;
      if (!ok || s_req !== 1'b1 || err !== 1'b1) begin
         $display("FAIL rst_pre: got ok=%b req=%b err=%b expected 1 1 1", ok, s_req, err);
         err_cnt++;
      end
      #2;
      reset = 1'b1;
      #1;
      vec_cnt++;
      if (s_req !== 1'b0 || err !== 1'b0 || m_ack !== 3'b000) begin
         $display("FAIL rst_async: got req=%b err=%b ack=%b expected 0 0 000", s_req, err, m_ack);
         err_cnt++;
      end
      m_req = '0;
      tick();
      reset = 1'b0;
      pulse_ack(16'hDEAD);
      vec_cnt++;
      if (m_ack !== 3'b000 || m_rdata !== 16'h0000 || s_req !== 1'b0) begin
         $display("FAIL rst_spurious: got ack=%b rdata=%h req=%b expected 000 0000 0",
                  m_ack, m_rdata, s_req);
         err_cnt++;
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_download();
      test_dl_mid_access();
      test_timeout();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
